// File: rtl/ram_16x8_arbiter.sv
// Round-robin arbiter and setup/strobe/hold sequencer for a 16x8 single-port
// RAM with a shared bidirectional data bus.
module ram_16x8_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              ram_write_en,
    output logic              ram_read_en,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    state_t state_q, state_d;

    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              pick;

    // On a tie the requester that was not granted last time wins.
    assign pick = (req0 && req1) ? ~last_q : req1;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_d   = pick;
                    last_d  = pick;
                    we_d    = pick ? we1 : we0;
                    addr_d  = pick ? addr1 : addr0;
                    wdata_d = pick ? wdata1 : wdata0;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = STROBE;
            STROBE: begin
                state_d = HOLD;
                if (!we_q) rdata_d = ram_data;
            end
            HOLD: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign ram_write_en = (state_q == STROBE) && we_q;
    assign ram_read_en  = (state_q == STROBE) && !we_q;
    assign ack0         = (state_q == HOLD) && !gnt_q;
    assign ack1         = (state_q == HOLD) && gnt_q;
    assign ram_addr     = addr_q;
    assign rdata        = rdata_q;

    // Bus is driven for the whole write sequence so HOLD gives data margin.
    assign ram_data = (busy && we_q) ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_16x8_arbiter.sv
// Self-checking bench for ram_16x8_arbiter with a behavioural RAM and
// a transaction-level reference model.
module tb_ram_16x8_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1, busy;
    logic [7:0] rdata;
    logic       ram_write_en, ram_read_en;
    logic [3:0] ram_addr;
    tri   [7:0] ram_data;

    int total = 0;
    int bad   = 0;

    logic [7:0] ram   [16];
    logic [7:0] mem_m [16];
    logic [7:0] rdata_m;
    int         last_m;

    ram_16x8_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .ram_write_en(ram_write_en), .ram_read_en(ram_read_en),
        .ram_addr(ram_addr), .ram_data(ram_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, write on the strobe edge.
    assign ram_data = ram_read_en ? ram[ram_addr] : 8'bz;
    always @(posedge clk) begin
        if (ram_write_en) ram[ram_addr] <= ram_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input bit on, input bit w,
                           input logic [3:0] a, input logic [7:0] d);
        if (i == 0) begin
            req0 = on; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = on; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    // Runs one access from the IDLE negedge: grant, SETUP, STROBE, HOLD, IDLE.
    task automatic txn(input int gi, input bit w, input logic [3:0] a,
                       input logic [7:0] d, input bit drop, input bit mutate);
        @(posedge clk);
        @(negedge clk);
        chk("setup_busy", busy, 1);
        chk("setup_addr", ram_addr, a);
        chk("setup_wen", ram_write_en, 0);
        chk("setup_ren", ram_read_en, 0);
        chk("setup_acks", {ack0, ack1}, 0);
        if (w) chk("setup_data", ram_data, d);
        if (mutate) begin
            addr0  = ~a;
            wdata0 = ~d;
        end
        @(posedge clk);
        @(negedge clk);
        chk("strobe_wen", ram_write_en, w);
        chk("strobe_ren", ram_read_en, !w);
        chk("strobe_addr", ram_addr, a);
        chk("strobe_busy", busy, 1);
        if (w) chk("strobe_data", ram_data, d);
        @(posedge clk);
        if (w) mem_m[a] = d;
        else rdata_m = mem_m[a];
        last_m = gi;
        @(negedge clk);
        chk("hold_ack0", ack0, gi == 0);
        chk("hold_ack1", ack1, gi == 1);
        chk("hold_rdata", rdata, rdata_m);
        chk("hold_ens", {ram_write_en, ram_read_en}, 0);
        chk("hold_addr", ram_addr, a);
        chk("hold_busy", busy, 1);
        if (w) chk("hold_data", ram_data, d);
        if (drop) set_req(gi, 0, w, a, d);
        @(posedge clk);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_acks", {ack0, ack1}, 0);
        chk("idle_ens", {ram_write_en, ram_read_en}, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && ram_write_en && ram_read_en) begin
            total++;
            bad++;
            $error("FAIL both_en observed=11 expected=not both");
        end
    end

    initial begin
        bit         pend [2];
        bit         pw   [2];
        logic [3:0] pa   [2];
        logic [7:0] pd   [2];
        int         w;

        for (int i = 0; i < 16; i++) begin
            ram[i]   = 8'h00;
            mem_m[i] = 8'h00;
        end
        rdata_m = 8'h00;
        last_m  = 1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        rst_n = 0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_acks", {ack0, ack1}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ens", {ram_write_en, ram_read_en}, 0);
        chk("rst_addr", ram_addr, 0);
        @(negedge clk);
        rst_n = 1;

        // Tie from reset: both write continuously, grants must alternate.
        set_req(0, 1, 1, 4'd0, 8'h11);
        set_req(1, 1, 1, 4'd15, 8'h22);
        txn(0, 1, 4'd0, 8'h11, 0, 0);
        txn(1, 1, 4'd15, 8'h22, 0, 0);
        txn(0, 1, 4'd0, 8'h11, 0, 0);
        txn(1, 1, 4'd15, 8'h22, 1, 0);
        set_req(0, 0, 0, 0, 0);
        set_req(0, 1, 0, 4'd0, 8'h00);
        txn(0, 0, 4'd0, 8'h00, 1, 0);
        set_req(1, 1, 0, 4'd15, 8'h00);
        txn(1, 0, 4'd15, 8'h00, 1, 0);
        chk("rb_addr15", rdata, 8'h22);

        // Write then read from the other requester.
        set_req(0, 1, 1, 4'd3, 8'hA5);
        txn(0, 1, 4'd3, 8'hA5, 1, 0);
        set_req(1, 1, 0, 4'd3, 8'h00);
        txn(1, 0, 4'd3, 8'h00, 1, 0);
        chk("wr_rd_a5", rdata, 8'hA5);

        // Read of 0x5A then a write: rdata must be retained.
        set_req(1, 1, 1, 4'd9, 8'h5A);
        txn(1, 1, 4'd9, 8'h5A, 1, 0);
        set_req(0, 1, 0, 4'd9, 8'h00);
        txn(0, 0, 4'd9, 8'h00, 1, 0);
        set_req(1, 1, 1, 4'd2, 8'hC3);
        txn(1, 1, 4'd2, 8'hC3, 1, 0);
        chk("rdata_keep", rdata, 8'h5A);

        // Inputs changed during SETUP must not reach the RAM.
        set_req(0, 1, 1, 4'd6, 8'h3E);
        txn(0, 1, 4'd6, 8'h3E, 1, 1);
        chk("mutate_ram6", ram[6], 8'h3E);

        // Reset during a write strobe; last pointer must return to 1.
        set_req(0, 1, 1, 4'd7, 8'h3C);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_wen", ram_write_en, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_acks", {ack0, ack1}, 0);
        chk("mid_rst_ens", {ram_write_en, ram_read_en}, 0);
        chk("mid_rst_addr", ram_addr, 0);
        chk("mid_rst_rdata", rdata, 0);
        set_req(0, 0, 0, 0, 0);
        rdata_m = 8'h00;
        last_m  = 1;
        @(negedge clk);
        chk("rst_hold_acks", {ack0, ack1}, 0);
        set_req(0, 1, 0, 4'd0, 8'h00);
        set_req(1, 1, 0, 4'd15, 8'h00);
        rst_n = 1;
        txn(0, 0, 4'd0, 8'h00, 1, 0);
        chk("post_rst_rd0", rdata, 8'h11);
        txn(1, 0, 4'd15, 8'h00, 1, 0);
        set_req(0, 1, 1, 4'd7, 8'h77);
        txn(0, 1, 4'd7, 8'h77, 1, 0);

        // Random traffic against the transaction model.
        pend[0] = 0;
        pend[1] = 0;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1;
                    pw[i] = 1'($urandom_range(0, 1));
                    pa[i] = 4'($urandom_range(0, 15));
                    pd[i] = 8'($urandom_range(0, 255));
                    set_req(i, 1, pw[i], pa[i], pd[i]);
                end
            end
            if (!pend[0] && !pend[1]) begin
                pend[0] = 1;
                pw[0] = 1'($urandom_range(0, 1));
                pa[0] = 4'($urandom_range(0, 15));
                pd[0] = 8'($urandom_range(0, 255));
                set_req(0, 1, pw[0], pa[0], pd[0]);
            end
            w = (pend[0] && pend[1]) ? 1 - last_m : (pend[1] ? 1 : 0);
            txn(w, pw[w], pa[w], pd[w], 1, 0);
            pend[w] = 0;
        end
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            if (i != 7) chk("final_ram", ram[i], mem_m[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_16x8_arbiter.md
# ram_16x8_arbiter

Two-requester round-robin arbiter and sequencer for the 16x8 single-port RAM with a shared bidirectional data bus. Each access is serialized into a fixed setup/strobe/hold sequence. The RAM's write/read enables and address are driven, and the shared data bus is driven only during writes. Read data is captured and returned to the granted requester with a one-cycle acknowledge. The block sits between two client engines and the RAM instance, and it is the sole driver of the RAM control pins.

## Interface
Parameters:
- ADDR_W, 4, RAM address width (16 words)
- DATA_W, 8, RAM word width

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0 / req1  input  1  access request from requester 0 / 1; held high until the matching ack
- we0 / we1  input  1  1 = write, 0 = read; stable while req is high
- addr0 / addr1  input  ADDR_W  word address
- wdata0 / wdata1  input  DATA_W  write data
- ack0 / ack1  output  1  one-cycle completion pulse
- rdata  output  DATA_W  read data for the last completed read, valid with ack
- busy  output  1  high whenever state != IDLE
- ram_write_en  output  1  to RAM write_en
- ram_read_en  output  1  to RAM read_en
- ram_addr  output  ADDR_W  to RAM addr
- ram_data  inout  DATA_W  to the RAM data bus; high-Z unless a write is in progress

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. Transitions are unconditional except in IDLE.
- IDLE:
  - Samples req0/req1.
  - If neither is high, stay in IDLE.
  - If exactly one is high, grant it.
  - If both are high, grant the requester that is not the `last` pointer.
  - On a grant: latch gnt, we, addr and wdata into internal registers, then go to SETUP.
- `last` pointer:
  - Reset value is 1, so requester 0 wins the first tie.
  - Updated to the granted index on every grant.
- SETUP:
  - ram_addr = latched addr; both enables are 0.
  - For a write, ram_data is driven with the latched wdata.
- STROBE:
  - For a write, ram_write_en = 1 and ram_data stays driven.
  - For a read, ram_read_en = 1 and ram_data is high-Z.
  - At the edge ending STROBE on a read, rdata is loaded from ram_data.
- HOLD:
  - Both enables are 0 and ram_addr is held.
  - For a write, ram_data stays driven; this is the hold margin for the RAM.
  - The ack for the granted requester is 1.
  - Next state is always IDLE.
- ram_write_en and ram_read_en are never high simultaneously.
- ram_data is high-Z in IDLE and for every read.
- rdata holds its value until the next read completes; writes do not alter it.
- Requester input changes after the IDLE grant edge are ignored until the next grant.

## Timing
- Reset (asynchronous, immediate) values:
  - State = IDLE; `last` = 1.
  - ack0 = ack1 = 0, busy = 0, rdata = 0.
  - ram_write_en = ram_read_en = 0, ram_addr = 0, ram_data = high-Z.
- Latency: with req high at grant edge E0, ack is high during the cycle that begins 2 edges after E0 (the HOLD cycle).
  - SETUP runs E0→E0+1, STROBE E0+1→E0+2, HOLD E0+2→E0+3.
- Throughput: one access per 4 cycles, because IDLE is always entered between accesses.
- Requester rule: on seeing ack at an edge, drop req at that same edge, or hold req high to request again. A req still high in IDLE is a new request.
- Boundary conditions:
  - Both requesters continuously requesting: grants alternate 0,1,0,1.
  - A single continuous requester gets a grant every 4 cycles.
  - Address 0 and address 15 require no special handling.
- Reset asserted mid-access: outputs drop to their reset values immediately and the pending ack is lost. The RAM word addressed by an interrupted write is undefined afterwards; all other words are unaffected.

## Test plan
- Write then read: req0 writes 0xA5 to addr 3, then req1 reads addr 3. Expect ack0 two edges after the grant, then ack1 with rdata = 0xA5. During the read, ram_data is high-Z with ram_read_en = 1.
- Tie arbitration: req0 and req1 held high from reset, with 0 writing 0x11 and 1 writing 0x22 to addrs 0 and 15. Expect the grant order 0,1,0,1 and ack pulses spaced 4 cycles apart. Read-back returns 0x11 from addr 0 and 0x22 from addr 15.
- Sequencing check: on every access, ram_write_en and ram_read_en are never both 1. Each enable is high for exactly one cycle, with ram_addr stable from SETUP through HOLD. For writes, ram_data is driven in SETUP, STROBE and HOLD.
- Reset mid-write: assert rst_n low during STROBE. All outputs go to their reset values immediately, ram_data becomes high-Z, and no ack is issued. After release, the first tie is granted to requester 0.
- Input change after grant: alter addr0 and wdata0 during SETUP. The RAM still receives the values latched at the grant edge.
- rdata retention: a read of 0x5A is followed by a write. rdata stays 0x5A, and busy is high for exactly 3 cycles per access.
